rotate_ctrl: RTL and testbench
==============================

# rotate_ctrl

Control stage directly upstream of the seven-segment rotating-pattern display. Conditions three raw push-buttons (pause, direction, speed) into clean single-press events and produces the `en` step strobe and `cw` direction level that the display stage consumes. Step rate is selectable in four levels derived from one clock divider.

## Interface
- `STEP_DIV`, default 50_000_000: clk cycles per step at speed 0; must be ≥ 8.
- `DB_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `btn_pause`  in  1  raw, asynchronous; press toggles running/paused.
- `btn_dir`  in  1  raw, asynchronous; press toggles `cw`.
- `btn_speed`  in  1  raw, asynchronous; press advances the speed level.
- `en`  out  1  one-cycle step strobe to the display stage.
- `cw`  out  1  rotation direction: 1 clockwise, 0 counter-clockwise.
- `running`  out  1  1 when strobes are being generated.
- `speed`  out  2  current speed level, 0 (slowest) to 3.

## Operation
- Reset values: `en`=0, `cw`=1, `running`=1, `speed`=0, step counter=0, every debouncer in IDLE_LO with its counter at 0.
- Each button uses one debouncer: 2-flop synchronizer, then a 4-state FSM: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
  - IDLE_LO→CHK_HI when synced=1. In CHK_HI, count while synced=1. Go to IDLE_HI at count DB_CYCLES-1 and emit a 1-cycle `press` pulse. Go back to IDLE_LO if synced=0.
  - IDLE_HI→CHK_LO when synced=0. Go to IDLE_LO after DB_CYCLES stable lows; return to IDLE_HI on any high. No pulse on release.
- Press effects, registered on the next edge:
  - pause press: toggle `running`.
  - dir press: toggle `cw`.
  - speed press: `speed` increments modulo 4 (3→0).
- Step generator: period P = STEP_DIV >> speed. Counter counts 0..P-1 while running. `en`=1 in the cycle the counter holds P-1; the counter then wraps to 0.
- While paused: counter held at 0 and `en`=0.
- Simultaneous events:
  - Presses on different buttons in the same cycle are all applied.
  - Pause press in a terminal-count cycle: `en` is suppressed that cycle.
  - Speed press in a terminal-count cycle: `en` still issues, then the counter restarts at 0 under the new P.
  - Speed press at any other time: the counter restarts at 0.
- `cw` is a level; it can change at any cycle and is independent of `en`.

## Timing
- Raw button edge to `cw`/`running`/`speed` change: DB_CYCLES+3 clk edges. This is 2 sync stages, DB_CYCLES counting cycles (the last of which emits `press`), and 1 for the control register.
- A glitch shorter than DB_CYCLES synced cycles produces no press.
- First `en` after reset release, resume, or speed change: P cycles after the counter is cleared, then every P cycles.
- At speed 3 with STEP_DIV=8, P=1 and `en` is high every cycle.
- `reset_n` low: all outputs go to reset values immediately, without a clock edge. Deassertion is expected synchronous to `clk` (external reset synchronizer).

## Configuration
- `ROTATE_CTRL_SPEED_EN` defined: the speed debouncer and speed register are built and operate as above.
- `ROTATE_CTRL_SPEED_EN` undefined:
  - `btn_speed` is ignored and no speed debouncer is instantiated.
  - `speed` is tied to 0 and P = STEP_DIV always.
  - Ports remain unchanged.

## Structure
- Package `rotate_pkg` holds:
  - `speed_t` (logic [1:0]);
  - `db_state_t` enum (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO);
  - default constants for STEP_DIV and DB_CYCLES.
- Sub-module `btn_debounce` (params DB_CYCLES; ports clk, reset_n, raw, level, press) is instantiated once per button.
- The step counter, control registers and `ifdef` gating live in `rotate_ctrl`.

## Test plan
All scenarios use STEP_DIV=8 and DB_CYCLES=4, with `ROTATE_CTRL_SPEED_EN` defined unless stated.
- Reset then release, no buttons → `en`=0,`cw`=1,`running`=1,`speed`=0 during reset; `en` pulses 1 cycle at cycles 8, 16, 24 after release.
- `btn_dir` high for 12 cycles then low → `cw` falls exactly 7 edges after the raw rise; no further change on release; `en` cadence unaffected.
- `btn_dir` high for 3 cycles (glitch) → no press, `cw` stays 1.
- Four speed presses → `speed` 1,2,3,0 with `en` periods 4, 2, 1 (continuous high), then 8. Repeat with the macro undefined → `speed` stays 0, period stays 8.
- Pause press → `running`=0 and no `en`. Second press → first `en` 8 cycles after `running` rises. Pause press landing on a terminal count → no `en` that cycle.
- Assert `reset_n` mid-period, between clock edges → outputs take reset values before the next edge. After release, first `en` comes 8 cycles later.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and default constants for the rotating-pattern control stage.
package rotate_pkg;

  typedef logic [1:0] speed_t;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } db_state_t;

  localparam int STEP_DIV_DEF  = 50_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a 4-state
// debounce FSM. Emits a one-cycle registered press pulse when a high level
// has been stable for DB_CYCLES synchronized samples; release is silent.
module btn_debounce
  import rotate_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  // The sample that leaves an IDLE state is the first stable one, so the
  // check state needs DB_CYCLES-1 further samples: the last accepted value
  // of the counter is DB_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

  logic             sync1_q;
  logic             sync2_q;
  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next-state: count consecutive stable samples in CHK states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce FSM state, counter and press pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level = (state_q == IDLE_HI) || (state_q == CHK_LO);
  assign press = press_q;

endmodule

// File: rtl/rotate_ctrl.sv
// Control stage for the rotating seven-segment display: debounces pause,
// direction and speed buttons and generates the en step strobe and cw level.
// Optional feature macro: ROTATE_CTRL_SPEED_EN builds the speed button path;
// without it speed is fixed at 0 and btn_speed is ignored.
module rotate_ctrl
  import rotate_pkg::*;
#(
  parameter int STEP_DIV  = STEP_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic       btn_speed,
  output logic       en,
  output logic       cw,
  output logic       running,
  output logic [1:0] speed
);

  localparam int CNT_W = $clog2(STEP_DIV);

  // Terminal count (P-1) for each speed level, P = STEP_DIV >> speed.
  function automatic logic [CNT_W-1:0] period_m1(input speed_t s);
    case (s)
      2'd0:    period_m1 = CNT_W'(STEP_DIV - 1);
      2'd1:    period_m1 = CNT_W'((STEP_DIV >> 1) - 1);
      2'd2:    period_m1 = CNT_W'((STEP_DIV >> 2) - 1);
      default: period_m1 = CNT_W'((STEP_DIV >> 3) - 1);
    endcase
  endfunction

  logic             pause_press;
  logic             dir_press;
  logic             speed_press;
  logic             unused_pause_lvl;
  logic             unused_dir_lvl;
  speed_t           speed_lvl;
  logic             running_q;
  logic             cw_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             term;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_pause),
    .level   (unused_pause_lvl),
    .press   (pause_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_dir),
    .level   (unused_dir_lvl),
    .press   (dir_press)
  );

`ifdef ROTATE_CTRL_SPEED_EN
  logic   unused_speed_lvl;
  speed_t speed_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_speed),
    .level   (unused_speed_lvl),
    .press   (speed_press)
  );

  // Speed level advances 0,1,2,3,0 on each speed press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= '0;
    end else if (speed_press) begin
      speed_q <= speed_q + 2'd1;
    end
  end

  assign speed_lvl = speed_q;
`else
  logic unused_btn_speed;

  assign unused_btn_speed = btn_speed;
  assign speed_press      = 1'b0;
  assign speed_lvl        = '0;
`endif

  // Pause and direction presses toggle their level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q <= 1'b1;
      cw_q      <= 1'b1;
    end else begin
      running_q <= running_q ^ pause_press;
      cw_q      <= cw_q ^ dir_press;
    end
  end

  // Step counter next value: cleared while paused, on pause/speed presses
  // and on terminal count; otherwise counts up.
  always_comb begin
    term  = (cnt_q == period_m1(speed_lvl));
    cnt_d = cnt_q + CNT_W'(1);
    if (!running_q || pause_press || speed_press || term) begin
      cnt_d = '0;
    end
  end

  // Step counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A pause press landing on terminal count swallows that strobe.
  assign en      = running_q & term & ~pause_press;
  assign cw      = cw_q;
  assign running = running_q;
  assign speed   = speed_lvl;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl with STEP_DIV=8, DB_CYCLES=4. A run-length button
// model plus an elapsed-cycle step model predicts every output each cycle;
// directed vectors pin the model with hand-computed values.
module tb_rotate_ctrl;

  localparam int STEP_DIV = 8;
  localparam int DB       = 4;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_dir   = 1'b0;
  logic       btn_speed = 1'b0;
  logic       en;
  logic       cw;
  logic       running;
  logic [1:0] speed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rotate_ctrl #(.STEP_DIV(STEP_DIV), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_pause (btn_pause),
    .btn_dir   (btn_dir),
    .btn_speed (btn_speed),
    .en        (en),
    .cw        (cw),
    .running   (running),
    .speed     (speed)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons index: 0 pause, 1 dir, 2 speed.
  int       m_n     = 0;   // clock edges since reset release
  int       m_t0    = 0;   // edge at which the step phase was last cleared
  bit       m_cw    = 1'b1;
  bit       m_run   = 1'b1;
  int       m_speed = 0;
  bit [2:0] m_d1    = '0;
  bit [2:0] m_d2    = '0;
  bit [2:0] m_deb   = '0;
  bit [2:0] m_press = '0;  // press pulse visible in the current cycle
  int       m_len[3] = '{0, 0, 0};

  always @(posedge clk or negedge reset_n) begin
    bit [2:0] raw;
    bit       s;
    if (!reset_n) begin
      m_n = 0; m_t0 = 0; m_cw = 1'b1; m_run = 1'b1; m_speed = 0;
      m_d1 = '0; m_d2 = '0; m_deb = '0; m_press = '0;
      for (int b = 0; b < 3; b++) m_len[b] = 0;
    end else begin
      raw = {btn_speed, btn_dir, btn_pause};
      m_n++;
      if (m_press[0]) begin
        m_run = !m_run;
        m_t0  = m_n;
      end
      if (m_press[1]) m_cw = !m_cw;
`ifdef ROTATE_CTRL_SPEED_EN
      if (m_press[2]) begin
        m_speed = (m_speed + 1) % 4;
        m_t0    = m_n;
      end
`endif
      m_press = '0;
      // A button level is accepted after DB consecutive differing samples
      // of the raw value delayed by two edges.
      for (int b = 0; b < 3; b++) begin
        s = m_d2[b];
        if (s != m_deb[b]) begin
          m_len[b]++;
          if (m_len[b] == DB) begin
            m_deb[b] = s;
            m_len[b] = 0;
            if (s) m_press[b] = 1'b1;
          end
        end else begin
          m_len[b] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int p;
    int exp_en;
    p      = STEP_DIV >> m_speed;
    exp_en = (m_run && (((m_n - m_t0) % p) == p - 1) && !m_press[0]) ? 1 : 0;
    check("model_en", int'(en), exp_en);
    check("model_cw", int'(cw), int'(m_cw));
    check("model_running", int'(running), int'(m_run));
    check("model_speed", int'(speed), m_speed);
  end

  // ---------------- directed stimulus ----------------
  task automatic press(input int which);
    if (which == 0) btn_pause = 1'b1;
    else if (which == 1) btn_dir = 1'b1;
    else btn_speed = 1'b1;
    repeat (6) @(negedge clk);
    btn_pause = 1'b0;
    btn_dir   = 1'b0;
    btn_speed = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic measure_period(output int p);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!en && c < 40);
    if (!en) check("period_wait_timeout", 0, 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!en && c < 40);
    p = c;
  endtask

  initial begin
    int c;
    int p;
    int exp_s;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_en", int'(en), 0);
    check("reset_cw", int'(cw), 1);
    check("reset_running", int'(running), 1);
    check("reset_speed", int'(speed), 0);
    reset_n = 1'b1;

    // en at cycles 8, 16, 24 after release
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check("en_cadence", int'(en), (i % 8 == 7) ? 1 : 0);
    end

    // 3-cycle glitch: no press
    btn_dir = 1'b1;
    repeat (3) @(negedge clk);
    btn_dir = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_cw", int'(cw), 1);

    // dir press: cw changes on the 7th edge after the raw rise
    btn_dir = 1'b1;
    repeat (6) @(negedge clk);
    check("dir_edge6_cw", int'(cw), 1);
    @(negedge clk);
    check("dir_edge7_cw", int'(cw), 0);
    repeat (5) @(negedge clk);
    btn_dir = 1'b0;
    repeat (12) @(negedge clk);
    check("dir_release_cw", int'(cw), 0);

    // four speed presses
    for (int k = 1; k <= 4; k++) begin
      press(2);
`ifdef ROTATE_CTRL_SPEED_EN
      exp_s = k % 4;
`else
      exp_s = 0;
`endif
      check("speed_level", int'(speed), exp_s);
      measure_period(p);
      check("speed_period", p, STEP_DIV >> exp_s);
    end

    // pause, then resume
    press(0);
    check("paused_running", int'(running), 0);
    c = 0;
    repeat (16) begin
      @(negedge clk);
      if (en) c++;
    end
    check("paused_en_count", c, 0);
    btn_pause = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!running && c < 30);
    check("resume_seen", int'(running), 1);
    btn_pause = 1'b0;
    c = 1;
    while (!en && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("resume_first_en", c, 8);

    // asynchronous reset mid-period
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_en", int'(en), 0);
    check("async_cw", int'(cw), 1);
    check("async_running", int'(running), 1);
    check("async_speed", int'(speed), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!en && c < 40);
    check("reset_first_en", c, 7);

    // pause press landing on the next terminal count (edge 15)
    repeat (2) @(negedge clk);
    btn_pause = 1'b1;
    repeat (6) @(negedge clk);
    check("term_en_suppressed", int'(en), 0);
    check("term_running", int'(running), 1);
    @(negedge clk);
    check("term_paused", int'(running), 0);
    btn_pause = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
